// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file.
package regfile_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;
    localparam int REG_NUM        = 32;
    localparam int REG_NUM_LOG2   = 5;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports with same-cycle
// write bypass, one clocked write port, $0 hardwired to zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_BUS_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // $0 has no storage; index 0 is never read from the array because the
    // read mux short-circuits it before the array lookup.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    // Register-write qualifier shared by storage update and bypass.
    logic wr_valid;
    assign wr_valid = (we == WRITE_ENABLE) && (waddr != '0);

    // Read mux in priority order: reset, disabled port, $0, bypass, storage.
    function automatic logic [DATA_W-1:0] rf_read(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        logic [DATA_W-1:0] val;
        if (rst == RST_ENABLE) begin
            val = '0;
        end else if (re != READ_ENABLE) begin
            val = '0;
        end else if (raddr == '0) begin
            val = '0;
        end else if (wr_valid && (waddr == raddr)) begin
            val = wdata;
        end else begin
            val = regs[raddr];
        end
        return val;
    endfunction

    // Storage: synchronous clear on reset drops any write in that cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1 (decode reg1).
    always_comb begin
        rdata1 = '0;
        rdata1 = rf_read(re1, raddr1);
    end

    // Read port 2 (decode reg2), identical to port 1 apart from its inputs.
    always_comb begin
        rdata2 = '0;
        rdata2 = rf_read(re2, raddr2);
    end

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed bench for the register file: reset, write/read, $0, bypass,
// read-enable gating and a back-to-back ori dependency.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int n_cmp;
    int n_bad;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 6;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL reset_comb_p1: got %h want %h", rdata1, 32'h0);
        end
        step();
        rst = 0;
        // write $5, then present a $6 write in the reset cycle
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        step();
        we = 0;
        re1 = 1; raddr1 = 5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL reset_prewrite: got %h want %h", rdata1, 32'hDEAD_BEEF);
        end
        rst = 1;
        we = 1; waddr = 6; wdata = 32'h0BAD_F00D;
        re2 = 1; raddr2 = 6;
        #1;
        n_cmp++;
        if (rdata2 !== 32'h0) begin
            n_bad++; $display("FAIL reset_no_bypass: got %h want %h", rdata2, 32'h0);
        end
        step();
        rst = 0; we = 0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL reset_clear_r5: got %h want %h", rdata1, 32'h0);
        end
        n_cmp++;
        if (rdata2 !== 32'h0) begin
            n_bad++; $display("FAIL reset_drop_r6: got %h want %h", rdata2, 32'h0);
        end
    endtask

    task automatic test_basic();
        idle();
        we = 1; waddr = 3; wdata = 32'h1234_5678;
        step();
        we = 0;
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 4;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h1234_5678) begin
            n_bad++; $display("FAIL basic_r3: got %h want %h", rdata1, 32'h1234_5678);
        end
        n_cmp++;
        if (rdata2 !== 32'h0) begin
            n_bad++; $display("FAIL basic_r4: got %h want %h", rdata2, 32'h0);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        re1 = 1; raddr1 = 0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL zero_same_cycle: got %h want %h", rdata1, 32'h0);
        end
        step();
        we = 0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL zero_next_cycle: got %h want %h", rdata1, 32'h0);
        end
    endtask

    task automatic test_bypass();
        idle();
        we = 1; waddr = 7; wdata = 32'h0000_0001;
        step();
        wdata = 32'hA5A5_A5A5;
        re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL bypass_p1: got %h want %h", rdata1, 32'hA5A5_A5A5);
        end
        n_cmp++;
        if (rdata2 !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL bypass_p2: got %h want %h", rdata2, 32'hA5A5_A5A5);
        end
        step();
        we = 0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL bypass_stored_p1: got %h want %h", rdata1, 32'hA5A5_A5A5);
        end
        n_cmp++;
        if (rdata2 !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL bypass_stored_p2: got %h want %h", rdata2, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_read_enable();
        idle();
        we = 1; waddr = 9; wdata = 32'hCAFE_0001;
        step();
        we = 0;
        re1 = 0; raddr1 = 9; re2 = 1; raddr2 = 9;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL re_gate_p1: got %h want %h", rdata1, 32'h0);
        end
        n_cmp++;
        if (rdata2 !== 32'hCAFE_0001) begin
            n_bad++; $display("FAIL re_open_p2: got %h want %h", rdata2, 32'hCAFE_0001);
        end
        we = 1; waddr = 9; wdata = 32'h5555_0002;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL re_gate_bypass_p1: got %h want %h", rdata1, 32'h0);
        end
        n_cmp++;
        if (rdata2 !== 32'h5555_0002) begin
            n_bad++; $display("FAIL re_bypass_p2: got %h want %h", rdata2, 32'h5555_0002);
        end
        re2 = 0;
        #1;
        n_cmp++;
        if (rdata2 !== 32'h0) begin
            n_bad++; $display("FAIL re_gate_bypass_p2: got %h want %h", rdata2, 32'h0);
        end
        step();
        we = 0;
    endtask

    task automatic test_back_to_back();
        idle();
        // decode ori $1,$0,0x1100 reads $0
        re1 = 1; raddr1 = 0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_bad++; $display("FAIL ori1_src: got %h want %h", rdata1, 32'h0);
        end
        // write-back of ori1 while decode of ori $2,$1,0x0020 reads $1
        we = 1; waddr = 1; wdata = 32'h0000_1100;
        raddr1 = 1;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0000_1100) begin
            n_bad++; $display("FAIL ori2_src_bypass: got %h want %h", rdata1, 32'h0000_1100);
        end
        step();
        we = 1; waddr = 2; wdata = 32'h0000_1120;
        step();
        we = 0;
        re1 = 1; raddr1 = 1; re2 = 1; raddr2 = 2;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0000_1100) begin
            n_bad++; $display("FAIL ori_r1: got %h want %h", rdata1, 32'h0000_1100);
        end
        n_cmp++;
        if (rdata2 !== 32'h0000_1120) begin
            n_bad++; $display("FAIL ori_r2: got %h want %h", rdata2, 32'h0000_1120);
        end
        // earlier contents survive unrelated writes
        raddr1 = 3; raddr2 = 9;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h1234_5678) begin
            n_bad++; $display("FAIL keep_r3: got %h want %h", rdata1, 32'h1234_5678);
        end
        n_cmp++;
        if (rdata2 !== 32'h5555_0002) begin
            n_bad++; $display("FAIL keep_r9: got %h want %h", rdata2, 32'h5555_0002);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1;
        idle();
        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_read_enable();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile
